// File: rtl/mem_arbiter.sv
// Two-master memory port arbiter: locks the port to I-CMU or D-CMU for a whole cs-high interval.
// Optional MEM_ARB_ROUND_ROBIN_EN: ties in S_IDLE alternate; otherwise D wins every tie.
//
// state   | meaning
// --------+----------------------------------------------
// S_IDLE  | no owner, arbitrate, all outputs quiet
// S_GNT_I | I-CMU owns the memory port
// S_GNT_D | D-CMU owns the memory port
// (3)     | illegal, outputs x, return to S_IDLE
module mem_arbiter #(
  parameter int ADDR_BITS     = 32,
  parameter int WORD_BITS     = 32,
  parameter int BEAT_CNT_BITS = 4
) (
  input  logic                     clk,
  input  logic                     rst,
  input  logic                     i_cs_i,
  input  logic                     i_we_i,
  input  logic [ADDR_BITS-1:0]     i_addr_i,
  input  logic [WORD_BITS-1:0]     i_data_i,
  output logic [WORD_BITS-1:0]     i_data_o,
  output logic                     i_ack_o,
  input  logic                     d_cs_i,
  input  logic                     d_we_i,
  input  logic [ADDR_BITS-1:0]     d_addr_i,
  input  logic [WORD_BITS-1:0]     d_data_i,
  output logic [WORD_BITS-1:0]     d_data_o,
  output logic                     d_ack_o,
  output logic                     mem_cs_o,
  output logic                     mem_we_o,
  output logic [ADDR_BITS-1:0]     mem_addr_o,
  output logic [WORD_BITS-1:0]     mem_data_o,
  input  logic [WORD_BITS-1:0]     mem_data_i,
  input  logic                     mem_ack_i,
  output logic [1:0]               arb_state,
  output logic [BEAT_CNT_BITS-1:0] arb_beats
);

  typedef enum logic [1:0] {
    S_IDLE  = 2'd0,
    S_GNT_I = 2'd1,
    S_GNT_D = 2'd2
  } state_t;

  state_t                   state_q, state_d;
  logic [BEAT_CNT_BITS-1:0] beats_q, beats_d;
  logic                     fwd_ack;
  logic                     tie_to_d;

`ifdef MEM_ARB_ROUND_ROBIN_EN
  logic last_d_q, last_d_d;

  // Tie goes to whoever did not win last time; reset value I hands the first tie to D.
  assign tie_to_d = ~last_d_q;

  always_comb begin
    last_d_d = last_d_q;
    if (state_q == S_IDLE && state_d == S_GNT_D) last_d_d = 1'b1;
    else if (state_q == S_IDLE && state_d == S_GNT_I) last_d_d = 1'b0;
  end

  always_ff @(posedge clk or negedge rst) begin
    if (!rst) last_d_q <= 1'b0;
    else      last_d_q <= last_d_d;
  end
`else
  assign tie_to_d = 1'b1;
`endif

  always_comb begin
    state_d    = state_q;
    mem_cs_o   = 1'b0;
    mem_we_o   = 1'b0;
    mem_addr_o = '0;
    mem_data_o = '0;
    i_ack_o    = 1'b0;
    d_ack_o    = 1'b0;
    i_data_o   = '0;
    d_data_o   = '0;
    fwd_ack    = 1'b0;
    case (state_q)
      S_IDLE: begin
        if (i_cs_i && d_cs_i) state_d = tie_to_d ? S_GNT_D : S_GNT_I;
        else if (d_cs_i)      state_d = S_GNT_D;
        else if (i_cs_i)      state_d = S_GNT_I;
      end
      S_GNT_I: begin
        mem_cs_o   = i_cs_i;
        mem_we_o   = i_we_i;
        mem_addr_o = i_addr_i;
        mem_data_o = i_data_i;
        i_ack_o    = mem_ack_i & i_cs_i;
        i_data_o   = mem_data_i;
        fwd_ack    = mem_ack_i & i_cs_i;
        if (!i_cs_i) state_d = S_IDLE;
      end
      S_GNT_D: begin
        mem_cs_o   = d_cs_i;
        mem_we_o   = d_we_i;
        mem_addr_o = d_addr_i;
        mem_data_o = d_data_i;
        d_ack_o    = mem_ack_i & d_cs_i;
        d_data_o   = mem_data_i;
        fwd_ack    = mem_ack_i & d_cs_i;
        if (!d_cs_i) state_d = S_IDLE;
      end
      default: begin
        mem_cs_o   = 1'bx;
        mem_we_o   = 1'bx;
        mem_addr_o = 'x;
        mem_data_o = 'x;
        i_ack_o    = 1'bx;
        d_ack_o    = 1'bx;
        i_data_o   = 'x;
        d_data_o   = 'x;
        state_d    = S_IDLE;
      end
    endcase
  end

  // Count holds its final value through the first idle cycle, then clears.
  always_comb begin
    beats_d = beats_q;
    if (state_q == S_IDLE)           beats_d = '0;
    else if (fwd_ack && !(&beats_q)) beats_d = beats_q + BEAT_CNT_BITS'(1);
  end

  always_ff @(posedge clk or negedge rst) begin
    if (!rst) begin
      state_q <= S_IDLE;
      beats_q <= '0;
    end else begin
      state_q <= state_d;
      beats_q <= beats_d;
    end
  end

  assign arb_state = state_q;
  assign arb_beats = beats_q;

endmodule

// File: tb/tb_mem_arbiter.sv
// Randomized bench for mem_arbiter against an ownership-based reference model.
module tb_mem_arbiter;
  localparam int AW = 32;
  localparam int WW = 32;
  localparam int BW = 4;

  logic          clk = 1'b0;
  logic          rst;
  logic          i_cs_i, i_we_i, d_cs_i, d_we_i, mem_ack_i;
  logic [AW-1:0] i_addr_i, d_addr_i;
  logic [WW-1:0] i_data_i, d_data_i, mem_data_i;
  logic [WW-1:0] i_data_o, d_data_o, mem_data_o;
  logic          i_ack_o, d_ack_o, mem_cs_o, mem_we_o;
  logic [AW-1:0] mem_addr_o;
  logic [1:0]    arb_state;
  logic [BW-1:0] arb_beats;

  mem_arbiter #(.ADDR_BITS(AW), .WORD_BITS(WW), .BEAT_CNT_BITS(BW)) dut (
    .clk(clk), .rst(rst),
    .i_cs_i(i_cs_i), .i_we_i(i_we_i), .i_addr_i(i_addr_i), .i_data_i(i_data_i),
    .i_data_o(i_data_o), .i_ack_o(i_ack_o),
    .d_cs_i(d_cs_i), .d_we_i(d_we_i), .d_addr_i(d_addr_i), .d_data_i(d_data_i),
    .d_data_o(d_data_o), .d_ack_o(d_ack_o),
    .mem_cs_o(mem_cs_o), .mem_we_o(mem_we_o), .mem_addr_o(mem_addr_o),
    .mem_data_o(mem_data_o), .mem_data_i(mem_data_i), .mem_ack_i(mem_ack_i),
    .arb_state(arb_state), .arb_beats(arb_beats)
  );

  always #5 clk = ~clk;

  int n_checks = 0;
  int n_errors = 0;

  task automatic check(input string tag, input logic [63:0] obs, input logic [63:0] exp);
    n_checks++;
    if (obs !== exp) begin
      n_errors++;
      $display("FAIL %s: got %0h, expected %0h (t=%0t)", tag, obs, exp, $time);
    end
  endtask

  // Reference model: who owns the port (0 none, 1 I, 2 D), acks counted this grant, last winner.
  int m_owner  = 0;
  int m_beats  = 0;
  bit m_last_d = 1'b0;
  int n_grants_d = 0;
  int n_grants_i = 0;

  task automatic model_reset();
    m_owner  = 0;
    m_beats  = 0;
    m_last_d = 1'b0;
  endtask

  task automatic model_check();
    logic          e_cs, e_we, e_iack, e_dack;
    logic [AW-1:0] e_addr;
    logic [WW-1:0] e_wdata, e_idata, e_ddata;
    e_cs = 0; e_we = 0; e_addr = '0; e_wdata = '0;
    e_iack = 0; e_dack = 0; e_idata = '0; e_ddata = '0;
    if (m_owner == 1) begin
      e_cs = i_cs_i; e_we = i_we_i; e_addr = i_addr_i; e_wdata = i_data_i;
      e_iack = mem_ack_i & i_cs_i; e_idata = mem_data_i;
    end else if (m_owner == 2) begin
      e_cs = d_cs_i; e_we = d_we_i; e_addr = d_addr_i; e_wdata = d_data_i;
      e_dack = mem_ack_i & d_cs_i; e_ddata = mem_data_i;
    end
    check("mem_cs",    64'(mem_cs_o),   64'(e_cs));
    check("mem_we",    64'(mem_we_o),   64'(e_we));
    check("mem_addr",  64'(mem_addr_o), 64'(e_addr));
    check("mem_wdata", 64'(mem_data_o), 64'(e_wdata));
    check("i_ack",     64'(i_ack_o),    64'(e_iack));
    check("d_ack",     64'(d_ack_o),    64'(e_dack));
    check("i_rdata",   64'(i_data_o),   64'(e_idata));
    check("d_rdata",   64'(d_data_o),   64'(e_ddata));
    check("arb_state", 64'(arb_state),  64'(m_owner));
    check("arb_beats", 64'(arb_beats),  64'(m_beats));
  endtask

  task automatic model_update();
    bit fwd;
    int win;
    fwd = (m_owner == 1 && i_cs_i && mem_ack_i) || (m_owner == 2 && d_cs_i && mem_ack_i);
    if (m_owner == 0) begin
      m_beats = 0;
      win = 0;
      if (i_cs_i && d_cs_i) begin
`ifdef MEM_ARB_ROUND_ROBIN_EN
        win = m_last_d ? 1 : 2;
`else
        win = 2;
`endif
      end else if (d_cs_i) win = 2;
      else if (i_cs_i)     win = 1;
      if (win != 0) m_last_d = (win == 2);
      if (win == 1) n_grants_i++;
      if (win == 2) n_grants_d++;
      m_owner = win;
    end else begin
      if (fwd && m_beats < (1 << BW) - 1) m_beats++;
      if ((m_owner == 1 && !i_cs_i) || (m_owner == 2 && !d_cs_i)) m_owner = 0;
    end
  endtask

  task automatic drive(input bit ics, input bit iwe, input logic [AW-1:0] ia, input logic [WW-1:0] id,
                       input bit dcs, input bit dwe, input logic [AW-1:0] da, input logic [WW-1:0] dd,
                       input bit ack, input logic [WW-1:0] rd);
    i_cs_i = ics; i_we_i = iwe; i_addr_i = ia; i_data_i = id;
    d_cs_i = dcs; d_we_i = dwe; d_addr_i = da; d_data_i = dd;
    mem_ack_i = ack; mem_data_i = rd;
  endtask

  // Entered one time unit after a rising edge with inputs already driven.
  task automatic cycle();
    #1;
    model_check();
    @(posedge clk);
    model_update();
    #1;
  endtask

  task automatic idle(input int n);
    for (int k = 0; k < n; k++) begin
      drive(0, 0, '0, '0, 0, 0, '0, '0, 0, '0);
      cycle();
    end
  endtask

  int          i_rem, d_rem;
  logic [AW-1:0] i_ad, d_ad;
  bit          i_wb, d_wb, ack, i_fwd, d_fwd;

  initial begin
    rst = 1'b0;
    drive(0, 0, '0, '0, 0, 0, '0, '0, 0, '0);
    model_reset();
    #12;
    model_check();
    rst = 1'b1;
    @(posedge clk);
    #1;

    // I-only fill of four words at 0x100.
    drive(1, 0, 32'h100, '0, 0, 0, '0, '0, 0, '0);
    cycle();
    for (int k = 0; k < 4; k++) begin
      drive(1, 0, 32'h100 + 32'(4 * k), '0, 0, 0, '0, '0, 1, 32'hA0 + 32'(k));
      cycle();
    end
    drive(0, 0, '0, '0, 0, 0, '0, '0, 0, '0);
    check("fill_beats", 64'(arb_beats), 64'd4);
    cycle();
    check("fill_idle", 64'(arb_state), 64'd0);
    idle(1);

    // Stray ack while idle.
    drive(0, 0, '0, '0, 0, 0, '0, '0, 1, 32'h55);
    cycle();
    cycle();
    check("stray_beats", 64'(arb_beats), 64'd0);

    // Simultaneous request, then D write-back/fill with I pending.
    drive(1, 0, 32'h40, '0, 1, 1, 32'h2000, 32'hD0, 0, '0);
    cycle();
    check("tie_owner_d", 64'(arb_state), 64'd2);
    for (int k = 0; k < 8; k++) begin
      drive(1, 0, 32'h40, '0, 1, k < 4, (k < 4 ? 32'h2000 : 32'h3000) + 32'(4 * (k % 4)),
            32'hD0 + 32'(k), 1, 32'hB0 + 32'(k));
      cycle();
    end
    check("wbfill_beats", 64'(arb_beats), 64'd8);
    drive(1, 0, 32'h40, '0, 0, 0, '0, '0, 0, '0);
    cycle();
    cycle();
    check("i_after_d", 64'(arb_state), 64'd1);
    drive(0, 0, '0, '0, 0, 0, '0, '0, 0, '0);
    cycle();
    idle(1);

    // Saturation of the beat counter on a long burst.
    drive(0, 0, '0, '0, 1, 0, 32'h500, '0, 0, '0);
    cycle();
    for (int k = 0; k < 18; k++) begin
      drive(0, 0, '0, '0, 1, 0, 32'h500 + 32'(4 * k), '0, 1, 32'(k));
      cycle();
    end
    check("beats_sat", 64'(arb_beats), 64'hF);
    idle(2);

    // Reset mid-burst after the second ack of an I fill.
    drive(1, 0, 32'h100, '0, 0, 0, '0, '0, 0, '0);
    cycle();
    for (int k = 0; k < 2; k++) begin
      drive(1, 0, 32'h100 + 32'(4 * k), '0, 0, 0, '0, '0, 1, 32'hA0 + 32'(k));
      cycle();
    end
    drive(1, 0, 32'h108, '0, 0, 0, '0, '0, 1, 32'hA2);
    rst = 1'b0;
    #1;
    check("rst_mem_cs", 64'(mem_cs_o), 64'd0);
    check("rst_state",  64'(arb_state), 64'd0);
    check("rst_beats",  64'(arb_beats), 64'd0);
    model_reset();
    drive(0, 0, '0, '0, 0, 0, '0, '0, 0, '0);
    #2;
    model_check();
    rst = 1'b1;
    @(posedge clk);
    #1;
    drive(1, 0, 32'h200, '0, 0, 0, '0, '0, 0, '0);
    cycle();
    check("post_rst_grant", 64'(arb_state), 64'd1);
    drive(0, 0, '0, '0, 0, 0, '0, '0, 0, '0);
    cycle();
    idle(1);

    // Randomized CMU-like traffic.
    i_rem = 0; d_rem = 0; i_ad = '0; d_ad = '0; i_wb = 0; d_wb = 0;
    for (int c = 0; c < 600; c++) begin
      if (i_rem == 0 && $urandom_range(0, 3) == 0) begin
        i_rem = ($urandom_range(0, 7) == 0) ? 18 : int'($urandom_range(1, 6));
        i_ad  = $urandom & 32'hFFFF_FFFC;
        i_wb  = 1'($urandom_range(0, 1));
      end
      if (d_rem == 0 && $urandom_range(0, 3) == 0) begin
        d_rem = ($urandom_range(0, 7) == 0) ? 18 : int'($urandom_range(1, 6));
        d_ad  = $urandom & 32'hFFFF_FFFC;
        d_wb  = 1'($urandom_range(0, 1));
      end
      ack = 1'($urandom_range(0, 1));
      drive(i_rem > 0, i_wb & 1'(i_rem % 2), i_ad, $urandom,
            d_rem > 0, d_wb & 1'(d_rem % 2), d_ad, $urandom, ack, $urandom);
      i_fwd = (m_owner == 1) && (i_rem > 0) && ack;
      d_fwd = (m_owner == 2) && (d_rem > 0) && ack;
      cycle();
      if (i_fwd) begin i_rem--; i_ad = i_ad + 32'd4; end
      if (d_fwd) begin d_rem--; d_ad = d_ad + 32'd4; end
    end
    idle(3);
    check("grants_seen", 64'((n_grants_i > 3) && (n_grants_d > 3)), 64'd1);

    $display("Simulation finished: %0d checks, %0d errors", n_checks, n_errors);
    $finish;
  end

endmodule

// File: doc/mem_arbiter.md
Name: mem_arbiter

Overview:
- Shares the single external memory port between two CMU masters: instruction cache (I, port `i_*`) and data cache (D, port `d_*`).
- Each CMU issues word-wise block transfers (write-back then fill) with a cs/we/addr/ack handshake.
- The arbiter locks the memory port to one master for the master's entire cs-high interval, so a BACK+FILL sequence is never interleaved.
- Sits between the two CMUs and the memory model/controller.

Parameters:
- ADDR_BITS, 32, memory address width.
- WORD_BITS, 32, data word width.
- BEAT_CNT_BITS, 4, width of per-grant ack counter (debug).

Ports:
- clk  input  1  system clock, rising edge.
- rst  input  1  asynchronous, active-low reset.
- i_cs_i  input  1  I-CMU memory request.
- i_we_i  input  1  I-CMU write enable.
- i_addr_i  input  ADDR_BITS  I-CMU address.
- i_data_i  input  WORD_BITS  I-CMU write data.
- i_data_o  output  WORD_BITS  read data to I-CMU.
- i_ack_o  output  1  ack to I-CMU.
- d_cs_i, d_we_i, d_addr_i, d_data_i, d_data_o, d_ack_o: same as above, for D-CMU.
- mem_cs_o  output  1  memory chip select.
- mem_we_o  output  1  memory write enable.
- mem_addr_o  output  ADDR_BITS  memory address.
- mem_data_o  output  WORD_BITS  memory write data.
- mem_data_i  input  WORD_BITS  memory read data.
- mem_ack_i  input  1  memory ack, one cycle per word.
- arb_state  output  2  debug: current state encoding.
- arb_beats  output  BEAT_CNT_BITS  debug: acks seen in current grant.

Behaviour:
- States:
  - S_IDLE=0: no owner.
  - S_GNT_I=1: I-CMU owns the port.
  - S_GNT_D=2: D-CMU owns the port.
  - Encoding 3 is illegal: outputs x, next state S_IDLE.
- Reset (rst low, asynchronous): state S_IDLE, arb_beats 0, last-winner flag = I.
- While in reset and in S_IDLE, every memory output is 0, both acks are 0, and both data outputs are 0.
- Arbitration happens in S_IDLE only:
  - Only one cs high: that master wins.
  - Both cs high: D wins (fixed priority; see optional feature).
  - Grant is registered: the winner's request reaches memory in the cycle after it is sampled in S_IDLE. Minimum arbitration latency is 1 cycle.
- In S_GNT_x:
  - mem_cs_o/we_o/addr_o/data_o are combinational copies of owner inputs.
  - owner ack_o = mem_ack_i & owner cs_i.
  - owner data_o = mem_data_i.
  - The non-owner sees ack 0 and data 0.
- Release:
  - Owner cs_i low in S_GNT_x → next state S_IDLE.
  - In that release cycle mem_cs_o is already 0 (combinational copy).
  - At least one S_IDLE cycle always separates two grants, including back-to-back requests from the same master.
- Requests from the non-owner are ignored (held pending by the CMU) until S_IDLE is reached. No preemption.
- mem_ack_i in S_IDLE, or while owner cs is low, is dropped and not forwarded.
- we may toggle within one grant (BACK→FILL); no re-arbitration occurs.
- arb_beats:
  - Cleared in S_IDLE.
  - Increments on each forwarded ack.
  - Saturates at all-ones.
- Reset asserted mid-grant: immediate return to S_IDLE; mem_cs_o drops asynchronously; the in-flight word is lost. The CMUs are reset by the same rst.

Optional Feature:
- Macro: MEM_ARB_ROUND_ROBIN_EN.
- Defined:
  - Tie in S_IDLE (both cs high) goes to the master that did NOT win the previous grant.
  - The last-winner flag updates on every S_IDLE→S_GNT transition; its reset value is I, so the first tie goes to D.
- Undefined: fixed D-over-I priority; the last-winner flag is not implemented.

Test Plan:
- I-only fill:
  - Stimulus: i_cs_i=1, we=0, addr 0x100; memory acks 4 words, 0xA0..0xA3 at 0x100/104/108/10C; then i_cs_i drops.
  - Response: mem_cs_o rises 1 cycle after request; i_ack_o pulses 4 times; d_ack_o stays 0; arb_beats=4; then S_IDLE.
- Simultaneous request (macro undefined):
  - Stimulus: i_cs_i and d_cs_i rise in the same cycle.
  - Response: D is granted first; mem_addr_o follows d_addr_i; I is granted only after D's cs drops plus 1 idle cycle.
- D write-back then fill:
  - Stimulus: d_we_i=1 for 4 acks to 0x2000..0x200C, then we=0 for 4 acks to 0x3000..0x300C, cs continuously high; i_cs_i asserted midway.
  - Response: no I grant until D releases; arb_beats=8; mem_we_o tracks d_we_i.
- Round robin (MEM_ARB_ROUND_ROBIN_EN):
  - Stimulus: both masters request continuously, each releasing after 4 acks.
  - Response: grant order D, I, D, I with exactly 1 S_IDLE cycle between grants.
- Stray ack:
  - Stimulus: mem_ack_i=1 in S_IDLE.
  - Response: i_ack_o=d_ack_o=0; arb_beats stays 0.
- Reset mid-burst:
  - Stimulus: rst low after the 2nd ack of an I fill.
  - Response: mem_cs_o=0 in the same cycle (async); arb_state=0; arb_beats=0; after rst high, a fresh request is granted normally.
